// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit counter encodings, saturating helpers and BTB entry metadata
package bp_pkg;
    typedef logic [1:0] ctr_t;
    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;
    typedef struct packed {
        logic valid;
        ctr_t ctr;
    } btb_meta_t;
    localparam btb_meta_t META_RST = '{valid: 1'b0, ctr: WNT};
    function automatic ctr_t sat_inc2(input ctr_t c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction
    function automatic ctr_t sat_dec2(input ctr_t c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction
endpackage

// File: rtl/btb_array.sv
// btb_array: direct-mapped BTB storage, async IF read port and sync read-modify-write training port
module btb_array
    import bp_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ENTRIES = 16,
    localparam int IDX_W = $clog2(ENTRIES),
    localparam int TAG_W = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_meta_t        rd_meta,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [XLEN-1:0]  wr_target
);
    btb_meta_t        meta_q   [ENTRIES];
    btb_meta_t        meta_d   [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];
    logic             wr_hit;

    assign rd_meta   = meta_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    // A missing not-taken branch is never allocated, so only taken misses replace the entry
    always_comb begin
        meta_d   = meta_q;
        tag_d    = tag_q;
        target_d = target_q;
        wr_hit   = meta_q[wr_idx].valid && (tag_q[wr_idx] == wr_tag);
        if (wr_en && wr_hit) begin
            meta_d[wr_idx].ctr = wr_taken ? sat_inc2(meta_q[wr_idx].ctr) : sat_dec2(meta_q[wr_idx].ctr);
            if (wr_taken) target_d[wr_idx] = wr_target;
        end else if (wr_en && wr_taken) begin
            meta_d[wr_idx]   = '{valid: 1'b1, ctr: WT};
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        if (!rst_n) meta_q <= '{default: META_RST};
        else        meta_q <= meta_d;
    end
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: IF-stage BTB predictor with ID-stage resolve, redirect and statistics
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             id_valid,
    input  logic             id_stall,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_taken,
    input  logic [XLEN-1:0]  id_target,
    input  logic             id_pred_taken,
    input  logic [XLEN-1:0]  id_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_meta_t        rd_meta;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_target;
    logic             hit;
    logic             upd;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    btb_array #(.XLEN(XLEN), .ENTRIES(ENTRIES)) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_meta   (rd_meta),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .wr_en     (upd),
        .wr_idx    (id_pc[IDX_W+1:2]),
        .wr_tag    (id_pc[XLEN-1:IDX_W+2]),
        .wr_taken  (id_taken),
        .wr_target (id_target)
    );

    // A stalled branch is evaluated only on its final ID cycle, so upd gates all effects
    always_comb begin
        hit           = rd_meta.valid && (rd_tag == if_pc[XLEN-1:IDX_W+2]);
        pred_taken    = hit && rd_meta.ctr[1];
        pred_target   = pred_taken ? rd_target : if_pc + XLEN'(4);
        upd           = id_valid && !id_stall;
        mispredict    = upd && ((id_taken != id_pred_taken) || (id_taken && (id_target != id_pred_target)));
        redirect_pc   = id_taken ? id_target : id_pc + XLEN'(4);
        branch_cnt_d  = (upd && !(&branch_cnt_q)) ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
        mispred_cnt_d = (mispredict && !(&mispred_cnt_q)) ? mispred_cnt_q + CNT_W'(1) : mispred_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule
